// File: rtl/cod_pkg.sv
// Shared constants and FSM state type for the 16-to-4 event encoder.
package cod_pkg;

    localparam int N_LINHAS = 16;
    localparam int W_COD    = 4;

    typedef enum logic {
        OCIOSO = 1'b0,
        SAIDA  = 1'b1
    } estado_t;

endpackage

// File: rtl/prio_16_4.sv
// Combinational priority selector: highest set bit wins, code = 15 - index.
module prio_16_4
    import cod_pkg::*;
(
    input  logic [N_LINHAS-1:0] cand,
    output logic [W_COD-1:0]    code,
    output logic                any
);

    // Ascending scan so the highest index is the last one written.
    always_comb begin
        code = '0;
        for (int i = 0; i < N_LINHAS; i++) begin
            if (cand[i]) begin
                code = W_COD'(N_LINHAS - 1 - i);
            end
        end
    end

    assign any = |cand;

endmodule

// File: rtl/cod_16_4.sv
// Sequential 16-to-4 event encoder with pending capture and valid/ack output.
module cod_16_4
    import cod_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [N_LINHAS-1:0] E,
    input  logic                ack,
    output logic [W_COD-1:0]    S,
    output logic                valid,
    output logic [N_LINHAS-1:0] pend,
    output logic                perda
);

    estado_t               estado;
    logic [N_LINHAS-1:0]   e_ant;
    logic [N_LINHAS-1:0]   edges;
    logic [N_LINHAS-1:0]   cand;
    logic [N_LINHAS-1:0]   sel_mask;
    logic [W_COD-1:0]      sel_code;
    logic                  any;

    assign edges    = E & ~e_ant;
    assign cand     = pend | edges;
    assign sel_mask = 16'h8000 >> sel_code;

    prio_16_4 u_prio (
        .cand (cand),
        .code (sel_code),
        .any  (any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= OCIOSO;
            e_ant  <= '0;
            pend   <= '0;
            S      <= '0;
            valid  <= 1'b0;
            perda  <= 1'b0;
        end else begin
            e_ant <= E;
            // A second edge on an already pending line is dropped.
            perda <= perda | (|(edges & pend));
            unique case (estado)
                OCIOSO: begin
                    if (any) begin
                        S      <= sel_code;
                        valid  <= 1'b1;
                        pend   <= cand & ~sel_mask;
                        estado <= SAIDA;
                    end else begin
                        pend <= cand;
                    end
                end
                SAIDA: begin
                    if (!ack) begin
                        pend <= cand;
                    end else if (any) begin
                        S    <= sel_code;
                        pend <= cand & ~sel_mask;
                    end else begin
                        valid  <= 1'b0;
                        pend   <= '0;
                        estado <= OCIOSO;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cod_16_4.sv
// Self-checking bench for cod_16_4: directed scenarios plus randomized run.
module tb_cod_16_4;

    logic        clk;
    logic        rst;
    logic [15:0] E;
    logic        ack;
    logic [3:0]  S;
    logic        valid;
    logic [15:0] pend;
    logic        perda;

    int errors;
    int checks;

    // Reference model state, kept as a set of pending lines and a shown code
    bit          m_pend [16];
    bit [15:0]   m_prev;
    bit          m_valid;
    int          m_code;
    bit          m_lost;
    int          emit_cnt [16];

    cod_16_4 dut (
        .clk   (clk),
        .rst   (rst),
        .E     (E),
        .ack   (ack),
        .S     (S),
        .valid (valid),
        .pend  (pend),
        .perda (perda)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] m_pend_vec();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // Drive one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic step(input logic r, input logic [15:0] e, input logic a);
        bit consume;
        bit cand [16];
        bit has;
        int best;
        @(negedge clk);
        rst = r;
        E   = e;
        ack = a;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 16; i++) m_pend[i] = 0;
            m_prev  = '0;
            m_valid = 0;
            m_code  = 0;
            m_lost  = 0;
        end else begin
            has  = 0;
            best = 16;
            for (int i = 0; i < 16; i++) begin
                bit ed;
                ed = e[i] && !m_prev[i];
                if (ed && m_pend[i]) m_lost = 1;
                cand[i] = m_pend[i] || ed;
            end
            m_prev  = e;
            consume = !m_valid || a;
            if (consume) begin
                for (int c = 0; c < 16; c++) begin
                    if (!has && cand[15 - c]) begin
                        has  = 1;
                        best = c;
                    end
                end
                if (has) begin
                    cand[15 - best] = 0;
                    m_code  = best;
                    m_valid = 1;
                    emit_cnt[best]++;
                end else begin
                    m_valid = 0;
                end
            end
            for (int i = 0; i < 16; i++) m_pend[i] = cand[i];
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 16'h0, 1'b0);
        step(1'b1, 16'h0, 1'b0);
        checks++;
        if (S !== 4'd0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out S=%0d valid=%b want S=0 valid=0", S, valid);
        end
        checks++;
        if (pend !== 16'h0 || perda !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags pend=%h perda=%b want 0000/0", pend, perda);
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 16'h0, 1'b0);
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_valid cyc=%0d got=%b want=0", k, valid);
            end
        end
    endtask

    task automatic test_single();
        step(1'b0, 16'h0400, 1'b0);
        checks++;
        if (valid !== 1'b1 || S !== 4'd5) begin
            errors++;
            $display("FAIL single_latency S=%0d valid=%b want S=5 valid=1", S, valid);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 16'h0, 1'b0);
            checks++;
            if (valid !== 1'b1 || S !== 4'd5) begin
                errors++;
                $display("FAIL single_hold cyc=%0d S=%0d valid=%b want 5/1", k, S, valid);
            end
        end
        step(1'b0, 16'h0, 1'b1);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL single_ack valid=%b want=0", valid);
        end
    endtask

    task automatic test_multi();
        int exp_seq [3];
        exp_seq[0] = 0;
        exp_seq[1] = 7;
        exp_seq[2] = 15;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 16'h8101, 1'b1);
            checks++;
            if (valid !== 1'b1 || S !== 4'(exp_seq[k])) begin
                errors++;
                $display("FAIL multi_order k=%0d S=%0d valid=%b want %0d/1",
                         k, S, valid, exp_seq[k]);
            end
        end
        step(1'b0, 16'h8101, 1'b1);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL multi_end valid=%b want=0", valid);
        end
        step(1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_loss();
        int n12;
        step(1'b0, 16'h8000, 1'b0);
        checks++;
        if (valid !== 1'b1 || S !== 4'd0) begin
            errors++;
            $display("FAIL loss_show S=%0d valid=%b want 0/1", S, valid);
        end
        n12 = emit_cnt[12];
        step(1'b0, 16'h0008, 1'b0);
        checks++;
        if (pend !== 16'h0008 || perda !== 1'b0) begin
            errors++;
            $display("FAIL loss_first pend=%h perda=%b want 0008/0", pend, perda);
        end
        step(1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0008, 1'b0);
        checks++;
        if (perda !== 1'b1) begin
            errors++;
            $display("FAIL loss_flag perda=%b want=1", perda);
        end
        step(1'b0, 16'h0, 1'b1);
        checks++;
        if (valid !== 1'b1 || S !== 4'd12) begin
            errors++;
            $display("FAIL loss_emit S=%0d valid=%b want 12/1", S, valid);
        end
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        checks++;
        if (valid !== 1'b0 || emit_cnt[12] - n12 != 1 || perda !== 1'b1) begin
            errors++;
            $display("FAIL loss_once valid=%b emits=%0d perda=%b want 0/1/1",
                     valid, emit_cnt[12] - n12, perda);
        end
    endtask

    task automatic test_retrigger();
        step(1'b1, 16'h0, 1'b0);
        step(1'b0, 16'h0400, 1'b0);
        step(1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0400, 1'b0);
        checks++;
        if (pend !== 16'h0400 || S !== 4'd5) begin
            errors++;
            $display("FAIL retrig_pend pend=%h S=%0d want 0400/5", pend, S);
        end
        step(1'b0, 16'h0, 1'b1);
        checks++;
        if (valid !== 1'b1 || S !== 4'd5 || perda !== 1'b0) begin
            errors++;
            $display("FAIL retrig_again S=%0d valid=%b perda=%b want 5/1/0",
                     S, valid, perda);
        end
        step(1'b0, 16'h0, 1'b1);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL retrig_end valid=%b want=0", valid);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 16'h8000, 1'b0);
        step(1'b0, 16'h00F0, 1'b0);
        checks++;
        if (valid !== 1'b1 || pend !== 16'h00F0) begin
            errors++;
            $display("FAIL mid_setup valid=%b pend=%h want 1/00f0", valid, pend);
        end
        step(1'b1, 16'h0002, 1'b0);
        checks++;
        if (valid !== 1'b0 || pend !== 16'h0 || S !== 4'd0 || perda !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset S=%0d valid=%b pend=%h perda=%b want 0/0/0000/0",
                     S, valid, pend, perda);
        end
        step(1'b0, 16'h0002, 1'b0);
        checks++;
        if (valid !== 1'b1 || S !== 4'd14) begin
            errors++;
            $display("FAIL mid_restart S=%0d valid=%b want 14/1", S, valid);
        end
        step(1'b0, 16'h0, 1'b1);
    endtask

    task automatic test_random();
        logic [15:0] e;
        e = '0;
        for (int k = 0; k < 400; k++) begin
            logic r;
            r = ($urandom_range(0, 63) == 0);
            e = e ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            step(r, e, 1'($urandom_range(0, 2) != 0));
            checks++;
            if (valid !== m_valid || pend !== m_pend_vec() || perda !== m_lost ||
                (m_valid && S !== 4'(m_code))) begin
                errors++;
                $display("FAIL random k=%0d S=%0d v=%b p=%h l=%b want S=%0d v=%b p=%h l=%b",
                         k, S, valid, pend, perda, m_code, m_valid, m_pend_vec(), m_lost);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        E      = '0;
        ack    = 1'b0;
        for (int i = 0; i < 16; i++) emit_cnt[i] = 0;
        test_reset();
        test_single();
        test_multi();
        test_loss();
        test_retrigger();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cod_16_4.md
# cod_16_4

Sequential 16-to-4 event encoder, the inverse of the team's 4-to-16 one-hot line decoder. Rising edges on 16 request lines are captured into a pending register and emitted one at a time as 4-bit codes. Emission uses a valid/ack handshake, and the code mapping is the exact inverse of the decoder: line bit 15 ↔ code 0, bit 0 ↔ code 15. It sits between front-panel/keypad-style request lines and the control logic that consumes one event per transaction.

## Interface
- No parameters; widths fixed at 16 lines / 4-bit code.
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- E  in  16  request lines, synchronous to clk (no internal synchronizer); bit 15 maps to code 0
- ack  in  1  consumer accepts current code when ack && valid at a clk edge
- S  out  4  encoded code; stable while valid=1 and not acked
- valid  out  1  S holds an unconsumed event
- pend  out  16  pending-event flags (same bit order as E)
- perda  out  1  sticky: an event was lost; cleared only by rst

## Operation
- Edge detect: register e_ant <= E each cycle; edges = E & ~e_ant.
- Candidates: cand = pend | edges.
- Selection: the lowest code wins, i.e. the highest set bit index of cand; code = 15 − index.
- FSM states:
  - OCIOSO (valid=0): if cand ≠ 0, load S with the selected code, set valid, clear the selected bit, and go to SAIDA. Otherwise stay.
  - SAIDA (valid=1): without ack, hold S unchanged and set pend |= edges. With ack, if (cand minus nothing) ≠ 0, load the next code back-to-back and stay in SAIDA. Otherwise clear valid and go to OCIOSO.
- The selected bit is never written into pend; all other cand bits are written into pend.
- Loss: an edge on a line whose pend bit is already 1 sets perda; the duplicate event is dropped.
- Re-trigger: an edge on the line currently shown in S (not yet acked) sets its pend bit and is emitted again later. This is not a loss.
- Reset values: S=4'b0000, valid=0, pend=16'h0000, perda=0, e_ant=16'h0000, state OCIOSO.
- Because e_ant resets to 0, lines already high at the first cycle after rst is deasserted count as edges.
- Reset mid-operation: rst overrides everything. A pending or shown event is discarded, with no ack required.

## Timing
- Latency: an edge first sampled at posedge t with the block idle gives valid=1 and the correct S after posedge t (0 extra cycles beyond the sampling edge).
- Throughput: one code per cycle while ack is held high and cand ≠ 0; there is no bubble between codes.
- After the final ack with cand = 0, valid=0 from the next edge.
- S, valid, pend and perda are registered outputs with no combinational path from E or ack.
- Simultaneous edges on several lines in one cycle: all are captured; they are emitted in ascending code order, one per accepted handshake.

## Structure
- Package cod_pkg: N_LINHAS=16, W_COD=4, state enum {OCIOSO, SAIDA}.
- Sub-module prio_16_4: purely combinational. Input cand[15:0]; outputs code[3:0] and any. Uses the same bit-to-code map as the decoder. It is reused by the top for selection.
- The top holds e_ant, pend, S, valid, perda and the FSM.

## Test plan
- Reset/idle: rst=1 for 2 cycles with E=0 → S=0, valid=0, pend=0, perda=0. With E=0 held for 5 cycles, valid stays 0.
- Single event: pulse E=16'h0400 (bit 10) for 1 cycle → valid=1, S=4'd5 after that edge. S is held with ack=0 for 3 cycles, then ack=1 for 1 cycle → valid=0 on the next edge.
- Multi-event ordering: in one cycle E goes 0 → 16'h8001 | 16'h0100 with ack held 1 → S sequence 0, 7, 15 on three consecutive cycles, then valid=0.
- Loss: pulse bit 3 (code 12) while code 0 is shown and unacked. Pulse bit 3 again 2 cycles later → perda=1 and code 12 is emitted exactly once.
- Re-trigger: while S=5 is shown, pulse bit 10 again and then ack → code 5 is emitted a second time and perda stays 0.
- Reset mid-operation: with valid=1 and pend=16'h00F0, assert rst for 1 cycle → all outputs return to reset values. With E held at 16'h0002 through reset, S=14 and valid=1 appear on the first edge after rst is deasserted.
